// File: rtl/lcd_vram_arbiter.sv
// Arbitrates one single-port VRAM between the LCD scan-out fetch path and a CPU
// req/ack port; display has priority, CPU is served after at most CPU_SLOT display grants.
module lcd_vram_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 8,
  parameter int CPU_SLOT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ovr_clr,
  output logic              disp_overrun
);

  localparam int STREAK_W = $clog2(CPU_SLOT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DISP_RD   = 3'd1,
    DISP_WAIT = 3'd2,
    CPU_ACC   = 3'd3,
    CPU_WAIT  = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                disp_pend;
  logic [ADDR_W-1:0]   disp_addr_q;
  logic [ADDR_W-1:0]   fetch_addr;
  logic [STREAK_W-1:0] streak;
  logic                decide;
  logic                disp_elig;
  logic                cpu_elig;
  logic                grant_disp;
  logic                grant_cpu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Arbitration: the CPU is masked while its own ack is still in flight so it is never served twice.
  always_comb begin
    decide     = (state == IDLE) || (state == DISP_WAIT) || (state == CPU_WAIT);
    disp_elig  = disp_pend | disp_req;
    cpu_elig   = cpu_req & ~cpu_ack & (state != CPU_WAIT);
    grant_cpu  = decide & cpu_elig & (~disp_elig | (streak == STREAK_W'(CPU_SLOT)));
    grant_disp = decide & disp_elig & ~grant_cpu;
    state_nxt  = state;
    case (state)
      DISP_RD: state_nxt = DISP_WAIT;
      CPU_ACC: state_nxt = CPU_WAIT;
      default: state_nxt = grant_disp ? DISP_RD : (grant_cpu ? CPU_ACC : IDLE);
    endcase
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      DISP_RD: begin
        ram_en   = 1'b1;
        ram_addr = fetch_addr;
      end
      CPU_ACC: begin
        ram_en    = 1'b1;
        ram_we    = cpu_we;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
      end
      default: ;
    endcase
  end

  // One-deep display request buffer; a request arriving while it is occupied is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_pend    <= 1'b0;
      disp_addr_q  <= '0;
      fetch_addr   <= '0;
      disp_overrun <= 1'b0;
    end else begin
      if (grant_disp) begin
        fetch_addr <= disp_pend ? disp_addr_q : disp_addr;
        disp_pend  <= 1'b0;
      end else if (disp_req && !disp_pend) begin
        disp_addr_q <= disp_addr;
        disp_pend   <= 1'b1;
      end
      if (disp_req && disp_pend) disp_overrun <= 1'b1;
      else if (ovr_clr)          disp_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (grant_disp || grant_cpu) begin
      if (grant_cpu || !cpu_elig)                streak <= '0;
      else if (streak != STREAK_W'(CPU_SLOT))    streak <= streak + 1'b1;
    end
  end

  // Response stage: RAM data captured in the wait state, completion pulses one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_valid <= 1'b0;
      disp_data  <= '0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      disp_valid <= (state == DISP_WAIT);
      cpu_ack    <= (state == CPU_WAIT);
      if (state == DISP_WAIT)            disp_data <= ram_rdata;
      if (state == CPU_WAIT && !cpu_we)  cpu_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_lcd_vram_arbiter.sv
// Directed bench for lcd_vram_arbiter with a behavioural 1-cycle-latency VRAM
// and queue-based scoreboards for display fetches and CPU completions.
module tb_lcd_vram_arbiter;
  localparam int ADDR_W   = 11;
  localparam int DATA_W   = 8;
  localparam int CPU_SLOT = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              disp_req = 1'b0;
  logic [ADDR_W-1:0] disp_addr = '0;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic              ovr_clr = 1'b0;
  logic              disp_overrun;

  lcd_vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CPU_SLOT(CPU_SLOT)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ovr_clr(ovr_clr), .disp_overrun(disp_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  typedef struct {
    logic [7:0] data;
    bit         is_rd;
    int         due;
  } exp_t;

  exp_t disp_q[$];
  exp_t cpu_q[$];

  function automatic logic [7:0] init_val(input logic [10:0] a);
    if (a == 11'h123) return 8'h41;
    return a[7:0] ^ {5'b0, a[10:8]} ^ 8'h3C;
  endfunction

  // Behavioural VRAM: read-first, 1-cycle read latency.
  logic [7:0] mem [0:2047];
  bit         written [0:2047];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= written[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
      if (ram_we) begin
        mem[ram_addr]     <= ram_wdata;
        written[ram_addr] <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_disp(input logic [7:0] d, input int due);
    exp_t e;
    e.data = d; e.is_rd = 1'b1; e.due = due;
    disp_q.push_back(e);
  endtask

  task automatic push_cpu(input logic [7:0] d, input bit is_rd, input int due);
    exp_t e;
    e.data = d; e.is_rd = is_rd; e.due = due;
    cpu_q.push_back(e);
  endtask

  // Scoreboard: every completion pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (disp_valid) begin
        if (disp_q.size() == 0) chk("disp_valid_unexpected", 64'(disp_valid), 64'd0);
        else begin
          e = disp_q.pop_front();
          chk("disp_data", 64'(disp_data), 64'(e.data));
          chk("disp_valid_cycle", 64'(cyc), 64'(e.due));
        end
      end
      if (cpu_ack) begin
        if (cpu_q.size() == 0) chk("cpu_ack_unexpected", 64'(cpu_ack), 64'd0);
        else begin
          e = cpu_q.pop_front();
          if (e.is_rd) chk("cpu_rdata", 64'(cpu_rdata), 64'(e.data));
          chk("cpu_ack_cycle", 64'(cyc), 64'(e.due));
        end
      end
      if (ram_en && ram_we) wr_cnt++;
    end
  end

  task automatic cpu_txn(input logic we, input logic [10:0] a, input logic [7:0] wd,
                         input logic [7:0] exp_rd);
    int t;
    tick();
    t = cyc;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    push_cpu(exp_rd, !we, t + 3);
    tick();
    chk("cpu_ram_en", 64'(ram_en), 64'd1);
    chk("cpu_ram_we", 64'(ram_we), 64'(we));
    chk("cpu_ram_addr", 64'(ram_addr), 64'(a));
    if (we) chk("cpu_ram_wdata", 64'(ram_wdata), 64'(wd));
    tick();
    chk("cpu_wait_ram_en", 64'(ram_en), 64'd0);
    tick();
    chk("cpu_ack_t3", 64'(cpu_ack), 64'd1);
    tick();
    cpu_req = 1'b0;
    chk("cpu_ack_pulse", 64'(cpu_ack), 64'd0);
  endtask

  task automatic ovr_seq(input logic [10:0] ca, input logic [10:0] a, input logic [10:0] b,
                         input logic clr_with_b);
    int t;
    tick();
    t = cyc;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = ca;
    push_cpu(init_val(ca), 1'b1, t + 3);
    tick();
    disp_req = 1'b1; disp_addr = a;
    push_disp(init_val(a), t + 5);
    tick();
    disp_addr = b; ovr_clr = clr_with_b;
    tick();
    disp_req = 1'b0; ovr_clr = 1'b0;
    chk("ovr_fetch_first_addr", 64'(ram_addr), 64'(a));
    chk("ovr_set", 64'(disp_overrun), 64'd1);
    tick();
    cpu_req = 1'b0;
    tick();
    tick();
    chk("ovr_dropped_no_fetch6", 64'(ram_en), 64'd0);
    tick();
    chk("ovr_dropped_no_fetch7", 64'(ram_en), 64'd0);
    chk("ovr_sticky", 64'(disp_overrun), 64'd1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("ovr_cleared", 64'(disp_overrun), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int  t;
    int  dcnt;
    bit  cpu_seen;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_outputs", 64'({ram_en, ram_we, ram_addr, ram_wdata, cpu_ack, cpu_rdata,
                            disp_valid, disp_data, disp_overrun}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Display fetch only
    tick();
    t = cyc;
    disp_req = 1'b1; disp_addr = 11'h123;
    push_disp(8'h41, t + 3);
    tick();
    disp_req = 1'b0;
    chk("disp_ram_en", 64'(ram_en), 64'd1);
    chk("disp_ram_we", 64'(ram_we), 64'd0);
    chk("disp_ram_addr", 64'(ram_addr), 64'h123);
    tick();
    tick();
    chk("disp_valid_t3", 64'(disp_valid), 64'd1);
    chk("disp_data_t3", 64'(disp_data), 64'h41);
    tick();
    chk("disp_valid_pulse", 64'(disp_valid), 64'd0);

    // CPU write then read back
    cpu_txn(1'b1, 11'h010, 8'h5A, 8'h00);
    cpu_txn(1'b0, 11'h010, 8'h00, 8'h5A);
    tick();
    chk("single_ram_write", 64'(wr_cnt), 64'd1);

    // Contention in one IDLE cycle
    tick();
    t = cyc;
    disp_req = 1'b1; disp_addr = 11'h200;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h300;
    push_disp(init_val(11'h200), t + 3);
    push_cpu(init_val(11'h300), 1'b1, t + 5);
    tick();
    disp_req = 1'b0;
    chk("cont_disp_first", 64'(ram_addr), 64'h200);
    tick();
    tick();
    chk("cont_cpu_next_en", 64'(ram_en), 64'd1);
    chk("cont_cpu_next_addr", 64'(ram_addr), 64'h300);
    tick();
    tick();
    chk("cont_cpu_ack", 64'(cpu_ack), 64'd1);
    tick();
    cpu_req = 1'b0;

    // Starvation bound: display pulses every 2 cycles while the CPU waits
    tick();
    t = cyc;
    dcnt = 0;
    cpu_seen = 1'b0;
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) tick();
      if (!cpu_seen && ram_en) begin
        if (ram_addr == 11'h7FF) begin
          cpu_seen = 1'b1;
          chk("starve_cpu_cycle", 64'(cyc - t), 64'd9);
          chk("starve_disp_grants", 64'(dcnt), 64'(CPU_SLOT));
        end else dcnt++;
      end
      if (k == 0) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h7FF;
        push_cpu(init_val(11'h7FF), 1'b1, t + 11);
      end
      if (k == 12) cpu_req = 1'b0;
      disp_req = (k <= 8) && (k % 2 == 0);
      disp_addr = 11'(11'h400 + k);
      if (disp_req) push_disp(init_val(11'(11'h400 + k)), (k == 8) ? t + 13 : t + k + 3);
    end
    disp_req = 1'b0;
    chk("starve_cpu_served", 64'(cpu_seen), 64'd1);
    chk("starve_no_overrun", 64'(disp_overrun), 64'd0);

    // Overrun, then overrun coincident with ovr_clr
    ovr_seq(11'h050, 11'h0A0, 11'h0B0, 1'b0);
    ovr_seq(11'h060, 11'h0C0, 11'h0D0, 1'b1);

    // Asynchronous reset in CPU_WAIT
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h111;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", 64'({ram_en, ram_we, ram_addr, ram_wdata, cpu_ack, cpu_rdata,
                               disp_valid, disp_data, disp_overrun}), 64'd0);
    cpu_req = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rst_no_ack", 64'(cpu_ack), 64'd0);
    end
    cpu_txn(1'b0, 11'h111, 8'h00, init_val(11'h111));

    repeat (4) tick();
    chk("disp_queue_drained", 64'(disp_q.size()), 64'd0);
    chk("cpu_queue_drained", 64'(cpu_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
